// File: rtl/gpio_controller_v2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_controller_v2_pkg
// Purpose  : Shared bus constants, register offsets and pin-direction encoding.
// Revision : 1.0
// ============================================================================
package gpio_controller_v2_pkg;

    localparam int BUS_WIDTH     = 32;
    localparam int BUS_ACC_WIDTH = 2;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [BUS_ACC_WIDTH-1:0] {
        ACC_1B = 2'd0,
        ACC_2B = 2'd1,
        ACC_4B = 2'd2
    } bus_acc_e;

    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = ACC_4B;

    localparam logic IOR_DIR_IN = 1'b0;

    localparam int unsigned GPIO_D     = 32'h00;
    localparam int unsigned GPIO_DIR   = 32'h04;
    localparam int unsigned GPIO_OSET  = 32'h08;
    localparam int unsigned GPIO_OCLR  = 32'h0C;
    localparam int unsigned GPIO_OTGL  = 32'h10;
    localparam int unsigned GPIO_IE    = 32'h14;
    localparam int unsigned GPIO_IRISE = 32'h18;
    localparam int unsigned GPIO_IFALL = 32'h1C;
    localparam int unsigned GPIO_ISTAT = 32'h20;

    function automatic logic is_write_only(input logic [31:0] off);
        return (off == GPIO_OSET) || (off == GPIO_OCLR) || (off == GPIO_OTGL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_controller_v2_if.sv
`default_nettype none
// ============================================================================
// Module   : gpio_controller_v2_if
// Purpose  : Single-cycle req/resp register bus between core and GPIO block.
// Revision : 1.0
// ============================================================================
interface gpio_controller_v2_if
    import gpio_controller_v2_pkg::*;
#(
    parameter int VA_WIDTH = 6
);
    logic [VA_WIDTH-1:0]      addr;
    logic                     w_rb;
    logic [BUS_ACC_WIDTH-1:0] acc;
    logic [BUS_WIDTH-1:0]     rdata;
    logic [BUS_WIDTH-1:0]     wdata;
    logic                     req;
    logic                     resp;
    logic                     fault;

    modport master (output addr, w_rb, acc, wdata, req, input rdata, resp, fault);
    modport slave  (input addr, w_rb, acc, wdata, req, output rdata, resp, fault);
endinterface
`default_nettype wire

// File: rtl/gpio_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : gpio_sync_edge
// Purpose  : Pad input synchroniser with edge detection, masked after reset.
// Revision : 1.0
// ============================================================================
module gpio_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);
    localparam int              PRIME_CYCLES = SYNC_STAGES + 1;
    localparam int              CNT_W        = $clog2(PRIME_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_PRIMED    = CNT_W'(PRIME_CYCLES);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_s_d;
    logic [CNT_W-1:0]                  r_prime_cnt;
    logic                              w_primed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync      <= '0;
            r_s_d       <= '0;
            r_prime_cnt <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i};
            r_s_d  <= r_sync[SYNC_STAGES-1];
            if (!w_primed) begin
                r_prime_cnt <= r_prime_cnt + CNT_W'(1);
            end
        end
    end

    // Until the chain has flushed the reset zeros, a high pad would look like a rising edge.
    assign w_primed = (r_prime_cnt == C_PRIMED);
    assign s        = r_sync[SYNC_STAGES-1];
    assign rise     = w_primed ? (s & ~r_s_d) : '0;
    assign fall     = w_primed ? (~s & r_s_d) : '0;
endmodule
`default_nettype wire

// File: rtl/gpio_controller_v2.sv
`default_nettype none
// ============================================================================
// Module   : gpio_controller_v2
// Purpose  : GPIO register file, bus decode, atomic output ops and edge IRQ.
// Revision : 1.0
// ============================================================================
module gpio_controller_v2
    import gpio_controller_v2_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int VA_WIDTH    = 6
) (
    input  logic               clk,
    input  logic               rst,
    output logic [WIDTH-1:0]   dir,
    input  logic [WIDTH-1:0]   i,
    output logic [WIDTH-1:0]   o,
    output logic               irq,
    gpio_controller_v2_if.slave bus
);
    logic [VA_WIDTH-1:0] w_addr;
    logic [31:0]         w_off;
    logic                w_in_map, w_ok, w_wr, w_rd, w_unused_wdata;
    logic [WIDTH-1:0]    w_wdata, w_s, w_rise, w_fall, w_cap, w_w1c, w_rd_val;

    logic [WIDTH-1:0]     r_o, r_dir, r_ie, r_irise, r_ifall, r_istat;
    logic                 r_resp, r_irq;
    logic [BUS_WIDTH-1:0] r_rdata;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .i    (i),
        .s    (w_s),
        .rise (w_rise),
        .fall (w_fall)
    );

    assign w_addr         = bus.addr;
    assign w_off          = 32'(w_addr);
    assign w_wdata        = bus.wdata[WIDTH-1:0];
    assign w_unused_wdata = ^bus.wdata;
    assign w_in_map       = (w_off <= GPIO_ISTAT) && (w_off[1:0] == 2'b00);

    assign bus.fault = bus.req & (~w_in_map | (bus.acc != BUS_ACC_4B) |
                                  (~bus.w_rb & is_write_only(w_off)));
    assign w_ok = bus.req & ~bus.fault;
    assign w_wr = w_ok & bus.w_rb;
    assign w_rd = w_ok & ~bus.w_rb;

    always_comb begin
        w_rd_val = '0;
        case (w_off)
            GPIO_D:     w_rd_val = w_s;
            GPIO_DIR:   w_rd_val = r_dir;
            GPIO_IE:    w_rd_val = r_ie;
            GPIO_IRISE: w_rd_val = r_irise;
            GPIO_IFALL: w_rd_val = r_ifall;
            GPIO_ISTAT: w_rd_val = r_istat;
            default:    w_rd_val = '0;
        endcase
    end

    // Capture is OR-ed in after the clear so a coincident edge keeps its bit set.
    assign w_cap = (w_rise & r_irise) | (w_fall & r_ifall);
    assign w_w1c = (w_wr && (w_off == GPIO_ISTAT)) ? w_wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_o     <= '0;
            r_dir   <= {WIDTH{IOR_DIR_IN}};
            r_ie    <= '0;
            r_irise <= '0;
            r_ifall <= '0;
            r_istat <= '0;
            r_resp  <= 1'b0;
            r_irq   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_resp  <= w_ok;
            r_irq   <= |(r_istat & r_ie);
            r_istat <= (r_istat & ~w_w1c) | w_cap;
            if (w_rd) begin
                r_rdata <= BUS_WIDTH'(w_rd_val);
            end
            if (w_wr) begin
                case (w_off)
                    GPIO_D:     r_o     <= w_wdata;
                    GPIO_DIR:   r_dir   <= w_wdata;
                    GPIO_OSET:  r_o     <= r_o | w_wdata;
                    GPIO_OCLR:  r_o     <= r_o & ~w_wdata;
                    GPIO_OTGL:  r_o     <= r_o ^ w_wdata;
                    GPIO_IE:    r_ie    <= w_wdata;
                    GPIO_IRISE: r_irise <= w_wdata;
                    GPIO_IFALL: r_ifall <= w_wdata;
                    default:    ;
                endcase
            end
        end
    end

    assign o         = r_o;
    assign dir       = r_dir;
    assign irq       = r_irq;
    assign bus.resp  = r_resp;
    assign bus.rdata = r_rdata;
endmodule
`default_nettype wire

// File: doc/gpio_controller_v2.md
Name: gpio_controller_v2

Overview:
- Parametrised next-generation GPIO peripheral on the single-cycle `req`/`resp` register bus.
- Adds over the previous generation:
  - configurable pin count;
  - a multi-stage input synchroniser;
  - atomic set/clear/toggle of output bits;
  - per-pin rising/falling edge capture, with a level interrupt to the core.

Parameters:
- WIDTH, 8, number of GPIO pins (1..32).
- SYNC_STAGES, 2, flip-flops in the input synchroniser (>=2).
- VA_WIDTH, 6, register address width (byte offsets).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- dir  out  WIDTH  per-pin direction to pads; pin is input when bit == `IOR_DIR_IN.
- i  in  WIDTH  asynchronous pad inputs.
- o  out  WIDTH  pad output values.
- irq  out  1  level interrupt, |(ISTAT & IE).
- addr  in  VA_WIDTH  register byte offset.
- w_rb  in  1  1 = write, 0 = read.
- acc  in  `BUS_ACC_WIDTH  access size.
- rdata  out  `BUS_WIDTH  read data, zero-extended above WIDTH.
- wdata  in  `BUS_WIDTH  write data; bits above WIDTH are ignored.
- req  in  1  access request, one cycle per access.
- resp  out  1  access complete.
- fault  out  1  combinational access error.

Behaviour:
- Register map. Each entry is offset, name, access; register bit 1 = output in DIR.
  - 0x00 D: R returns synchronised input; W writes o.
  - 0x04 DIR: R/W; 1 = output.
  - 0x08 OSET: W only; o |= wdata.
  - 0x0C OCLR: W only; o &= ~wdata.
  - 0x10 OTGL: W only; o ^= wdata.
  - 0x14 IE: R/W.
  - 0x18 IRISE: R/W; enables rising-edge capture per pin.
  - 0x1C IFALL: R/W; enables falling-edge capture per pin.
  - 0x20 ISTAT: R, W1C.
- Fault conditions:
  - fault = req & (addr not in map | acc != `BUS_ACC_4B | read of OSET/OCLR/OTGL).
  - On fault: no resp, no register update.
- Response timing:
  - resp asserts exactly one cycle after a valid req.
  - rdata is registered, valid in the resp cycle, and holds until the next read.
  - Back-to-back req on consecutive cycles is supported.
- Reset values:
  - resp = 0, irq = 0, o = 0, dir = all `IOR_DIR_IN (DIR reads 0).
  - IE, IRISE, IFALL, ISTAT = 0; rdata = 0; synchroniser stages = 0.
- Input path:
  - i passes through SYNC_STAGES flops to give s; one more flop holds s_d.
  - rise = s & ~s_d; fall = ~s & s_d.
  - D read returns s, i.e. input latency SYNC_STAGES cycles.
- Edge capture:
  - ISTAT[k] sets when (rise[k] & IRISE[k]) | (fall[k] & IFALL[k]).
  - Edge capture runs regardless of DIR, so output-pin loopback is capturable.
- Post-reset masking:
  - Edge detection is masked for SYNC_STAGES+1 cycles after rst deasserts.
  - A small counter implements this, saturating to 'primed'.
  - Prevents spurious edges from a high pin after reset.
- ISTAT write-1-to-clear:
  - Write clears bits where wdata = 1.
  - If a capture event on bit k coincides with a W1C of bit k, the set wins and ISTAT[k] stays 1.
  - Write of 0s has no effect.
- irq is registered: it follows ISTAT/IE changes one cycle later. It stays high until the cause is cleared or masked.
- Disabling IRISE/IFALL does not clear pending ISTAT bits.
- Reset asserted mid-access: resp is forced 0 next cycle; the pending access is dropped.

Decomposition:
- Shared header (`gpio_defs.vh`) holds:
  - register offset constants (GPIO_D, GPIO_DIR, GPIO_OSET, GPIO_OCLR, GPIO_OTGL, GPIO_IE, GPIO_IRISE, GPIO_IFALL, GPIO_ISTAT);
  - `IOR_DIR_IN`;
  - default WIDTH.
- Sub-module gpio_sync_edge (WIDTH, SYNC_STAGES) contains the synchroniser chain, s_d, rise/fall outputs and post-reset priming.
- Top level holds the register file, bus decode and irq.

Test Plan:
- Reset, then read all registers -> D = synced i; DIR/IE/IRISE/IFALL/ISTAT = 0; dir = all `IOR_DIR_IN; resp exactly 1 cycle after each req.
- Write D = 0x0F, OSET 0x30, OCLR 0x03, OTGL 0x81 -> o = 0x0F, 0x3F, 0x3C, 0xBD; read of OSET -> fault = 1, no resp.
- IRISE = 0x01, IFALL = 0x02, IE = 0x03; toggle i[0] 0→1 and i[1] 1→0 -> ISTAT = 0x03 after SYNC_STAGES+1 cycles; irq high one cycle later; W1C 0x01 -> ISTAT = 0x02, irq stays high.
- Hold i = 0xFF through rst, IRISE = 0xFF -> ISTAT stays 0 (no spurious edge).
- W1C ISTAT bit 0 in the same cycle as a new rising edge on pin 0 -> ISTAT[0] remains 1.
- addr = 0x24, addr = 0x02, and acc = 1B -> fault = 1 each time, no resp, registers unchanged.
